// File: rtl/vx_dispatch_pkt_arb_if.sv
// Dispatch bundle between the issue slices and a single functional-unit port.
interface vx_dispatch_pkt_arb_if #(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned REQ_SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
    // Request side: one beat lane per issue slice
    logic [NUM_REQS-1:0]                 req_valid;
    logic [NUM_REQS-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQS-1:0]                 req_sop;
    logic [NUM_REQS-1:0]                 req_eop;
    logic [NUM_REQS-1:0]                 req_ready;

    // Unit side: registered beat plus its source index
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_sop;
    logic                    out_eop;
    logic [REQ_SEL_BITS-1:0] out_sel;
    logic                    out_ready;

    // Driver of requests and consumer of the dispatched beat
    modport master (
        output req_valid, req_data, req_sop, req_eop, out_ready,
        input  req_ready, out_valid, out_data, out_sop, out_eop, out_sel
    );

    // The arbiter itself
    modport slave (
        input  req_valid, req_data, req_sop, req_eop, out_ready,
        output req_ready, out_valid, out_data, out_sop, out_eop, out_sel
    );
endinterface

// File: rtl/vx_dispatch_pkt_arb.sv
// Packet-aware round-robin arbiter: shares one dispatch port between issue
// slices, locking the grant to a slice from its first beat until its eop,
// with a single registered output stage towards the unit.
module vx_dispatch_pkt_arb #(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned REQ_SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vx_dispatch_pkt_arb_if.slave   bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    lock_state_t             lock_state;
    logic [REQ_SEL_BITS-1:0] rr_ptr;
    logic [REQ_SEL_BITS-1:0] lock_idx;

    logic [REQ_SEL_BITS-1:0] grant_idx;
    logic [REQ_SEL_BITS-1:0] cand_idx;
    int unsigned             cand;
    logic                    grant_any;
    logic                    stage_ready;
    logic                    xfer;
    logic                    xfer_eop;

    // Pick the eligible slice: the lock owner, or the first valid slice from rr_ptr
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        cand_idx  = '0;
        if (lock_state == LOCKED) begin
            grant_any = bus.req_valid[lock_idx];
            grant_idx = lock_idx;
        end else begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                cand = 32'(rr_ptr) + i;
                if (cand >= NUM_REQS) begin
                    cand = cand - NUM_REQS;
                end
                cand_idx = REQ_SEL_BITS'(cand);
                if (!grant_any && bus.req_valid[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    // Handshake: the stage accepts when empty or draining; ready is held off in reset
    always_comb begin
        stage_ready   = !bus.out_valid || bus.out_ready;
        xfer          = grant_any && stage_ready && reset_n;
        xfer_eop      = bus.req_eop[grant_idx];
        bus.req_ready = xfer ? (NUM_REQS'(1) << grant_idx) : '0;
    end

    // Lock state and round-robin pointer; only eop beats release the lock and advance rr_ptr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state <= IDLE;
            lock_idx   <= '0;
            rr_ptr     <= '0;
        end else if (xfer) begin
            if (xfer_eop) begin
                lock_state <= IDLE;
                rr_ptr     <= (grant_idx == REQ_SEL_BITS'(NUM_REQS - 1))
                              ? '0 : grant_idx + REQ_SEL_BITS'(1);
            end else begin
                lock_state <= LOCKED;
                lock_idx   <= grant_idx;
            end
        end
    end

    // Output register: load on any transfer, otherwise drain when the unit accepts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_sel   <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.req_data[grant_idx];
            bus.out_sop   <= bus.req_sop[grant_idx];
            bus.out_eop   <= xfer_eop;
            bus.out_sel   <= grant_idx;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
